// File: rtl/imem_arb_pkg.sv
// Shared widths, response-owner encoding and helpers for the instruction/data
// memory arbiter.
package imem_arb_pkg;

    localparam int ADDR_WIDTH           = 32;
    localparam int DATA_WIDTH           = 32;
    localparam int INSTR_WIDTH          = 32;
    localparam int DEFAULT_STARVE_LIMIT = 3;

    localparam logic [3:0] FETCH_BE = 4'hF;

    // Who owns the response that memory returns on the next ready cycle.
    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_IF    = 2'd1,
        RSP_DM_RD = 2'd2
    } rsp_own_e;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/imem_arb_if.sv
// Bundle of the fetch, data-side and memory-side signals around the arbiter.
// slave = arbiter view, master = core/memory environment view.
interface imem_arb_if;
    import imem_arb_pkg::*;

    logic                   if_req;
    logic [ADDR_WIDTH-1:0]  if_addr;
    logic                   if_flush;
    logic                   if_gnt;
    logic                   if_rvalid;
    logic [INSTR_WIDTH-1:0] if_rdata;

    logic                   dm_req;
    logic                   dm_we;
    logic [3:0]             dm_be;
    logic [ADDR_WIDTH-1:0]  dm_addr;
    logic [DATA_WIDTH-1:0]  dm_wdata;
    logic                   dm_gnt;
    logic                   dm_rvalid;
    logic [DATA_WIDTH-1:0]  dm_rdata;

    logic                   mem_cs;
    logic                   mem_we;
    logic [3:0]             mem_be;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic                   mem_ready;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_cs, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_cs, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/imem_arb_prio.sv
// Grant selection: data side wins by default, fetch is forced through after
// STARVE_LIMIT consecutive data grants while it waits.
module imem_arb_prio
    import imem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic cpu_clk,
    input  logic cpu_rstn,
    input  logic mem_ready,
    input  logic if_req,
    input  logic dm_req,
    output logic if_gnt,
    output logic dm_gnt
);

    localparam int            CW      = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] starve_cnt_reg;
    logic [CW-1:0] starve_cnt_next;
    logic          fetch_due;

    always_comb begin
        fetch_due = (starve_cnt_reg == LIMIT);
        // Grants are gated by reset so nothing reaches memory while held in reset.
        if_gnt    = cpu_rstn & mem_ready & if_req & (~dm_req | fetch_due);
        dm_gnt    = cpu_rstn & mem_ready & dm_req & ~(if_req & fetch_due);

        starve_cnt_next = starve_cnt_reg;
        if (!if_req || if_gnt) begin
            starve_cnt_next = '0;
        end else if (dm_gnt && (starve_cnt_reg != LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

endmodule

// File: rtl/imem_arb.sv
// Single-port memory arbiter between instruction fetch and data side: one access
// per ready cycle, response returned on the next ready cycle to its owner.
module imem_arb
    import imem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input logic       cpu_clk,
    input logic       cpu_rstn,
    imem_arb_if.slave bus
);

    logic                  if_gnt;
    logic                  dm_gnt;
    logic                  grant;
    logic                  if_rvalid;
    logic                  dm_rvalid;

    rsp_own_e              rsp_own_reg;
    rsp_own_e              rsp_own_next;
    logic                  cancel_reg;
    logic                  cancel_next;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  we_reg;
    logic [3:0]            be_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;

    imem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .cpu_clk   (cpu_clk),
        .cpu_rstn  (cpu_rstn),
        .mem_ready (bus.mem_ready),
        .if_req    (bus.if_req),
        .dm_req    (bus.dm_req),
        .if_gnt    (if_gnt),
        .dm_gnt    (dm_gnt)
    );

    assign grant = if_gnt | dm_gnt;

    // The owner only advances when memory completes the outstanding data phase.
    always_comb begin
        rsp_own_next = rsp_own_reg;
        cancel_next  = cancel_reg;
        if (bus.mem_ready) begin
            cancel_next = 1'b0;
            if (if_gnt) begin
                rsp_own_next = RSP_IF;
            end else if (dm_gnt && !bus.dm_we) begin
                rsp_own_next = RSP_DM_RD;
            end else begin
                rsp_own_next = RSP_NONE;
            end
        end else if ((rsp_own_reg == RSP_IF) && bus.if_flush) begin
            cancel_next = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            rsp_own_reg <= RSP_NONE;
            cancel_reg  <= 1'b0;
        end else begin
            rsp_own_reg <= rsp_own_next;
            cancel_reg  <= cancel_next;
        end
    end

    // Last issued access, so the memory bus holds steady while idle or stalled.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            be_reg    <= '0;
            wdata_reg <= '0;
        end else if (grant) begin
            addr_reg <= if_gnt ? bus.if_addr : bus.dm_addr;
            we_reg   <= dm_gnt & bus.dm_we;
            be_reg   <= if_gnt ? FETCH_BE : bus.dm_be;
            if (dm_gnt) begin
                wdata_reg <= bus.dm_wdata;
            end
        end
    end

    // A flush arriving in the retirement cycle itself must also drop the response.
    assign if_rvalid = bus.mem_ready & (rsp_own_reg == RSP_IF) & ~cancel_reg & ~bus.if_flush;
    assign dm_rvalid = bus.mem_ready & (rsp_own_reg == RSP_DM_RD);

    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.dm_rvalid = dm_rvalid;
    assign bus.if_rdata  = if_rvalid ? bus.mem_rdata[INSTR_WIDTH-1:0] : '0;
    assign bus.dm_rdata  = dm_rvalid ? bus.mem_rdata : '0;

    assign bus.mem_cs    = grant;
    assign bus.mem_we    = if_gnt ? 1'b0     : (dm_gnt ? bus.dm_we    : we_reg);
    assign bus.mem_be    = if_gnt ? FETCH_BE : (dm_gnt ? bus.dm_be    : be_reg);
    assign bus.mem_addr  = if_gnt ? bus.if_addr : (dm_gnt ? bus.dm_addr : addr_reg);
    assign bus.mem_wdata = dm_gnt ? bus.dm_wdata : wdata_reg;

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 STARVE_LIMIT, 3, maximum consecutive data-side grants while a fetch request waits.
REQ-002 cpu_clk  in  1  CPU clock; all state updates on its rising edge.
REQ-003 cpu_rstn  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  fetch read request, held until granted.
REQ-005 if_addr  in  ADDR_WIDTH  fetch word address (from fetch next_pc).
REQ-006 if_flush  in  1  fetch redirect (jal/jalr/branch/trap/mret); cancels pending fetch response.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  fetch read data valid (instr_read_data_valid).
REQ-009 if_rdata  out  INSTR_WIDTH  fetch read data.
REQ-010 dm_req  in  1  data-side request, held until granted.
REQ-011 dm_we  in  1  data-side write (1) / read (0).
REQ-012 dm_be  in  4  data-side byte enables.
REQ-013 dm_addr  in  ADDR_WIDTH  data-side address.
REQ-014 dm_wdata  in  DATA_WIDTH  data-side write data.
REQ-015 dm_gnt  out  1  data request accepted this cycle.
REQ-016 dm_rvalid  out  1  data read data valid (reads only).
REQ-017 dm_rdata  out  DATA_WIDTH  data read data.
REQ-018 mem_cs  out  1  memory access strobe.
REQ-019 mem_we  out  1  memory write.
REQ-020 mem_be  out  4  memory byte enables; 4'hF for fetch.
REQ-021 mem_addr  out  ADDR_WIDTH  memory address.
REQ-022 mem_wdata  out  DATA_WIDTH  memory write data.
REQ-023 mem_rdata  in  DATA_WIDTH  memory read data, valid one ready cycle after accepted access.
REQ-024 mem_ready  in  1  memory accepts new access and completes prior data phase; low = stall, all mem_* outputs held.

Function
REQ-025 Pipelined single-port sharing: at most one access issued per cycle with mem_ready=1; response returns next mem_ready=1 cycle.
REQ-026 Grant only when mem_ready=1; mem_cs=if_gnt|dm_gnt; never both grants same cycle.
REQ-027 Default priority data over fetch; starve_cnt counts consecutive dm grants while if_req=1; at starve_cnt==STARVE_LIMIT fetch granted next, then starve_cnt cleared.
REQ-028 starve_cnt cleared on any fetch grant or when if_req=0; saturates, never wraps.
REQ-029 Response owner register rsp_own in {NONE, IF, DM_RD}: loaded on grant (DM write -> NONE), advanced only when mem_ready=1.
REQ-030 if_rvalid=1 iff rsp_own==IF and mem_ready=1 and not cancelled; dm_rvalid likewise for DM_RD; rdata driven from mem_rdata, zero when not valid.
REQ-031 if_flush with rsp_own==IF sets cancel flag; response suppressed, flag cleared when that response retires; flush while mem_ready=0 held until retirement.
REQ-032 if_flush same cycle as if_req grant: grant proceeds (new address), only older response cancelled.
REQ-033 Writes produce no rvalid; write followed by read to same address returns written data (memory ordering preserved, no reordering).
REQ-034 Idle (no requests): mem_cs=0, other mem_* hold last value.

Reset
REQ-035 On cpu_rstn=0 asynchronously: rsp_own=NONE, cancel=0, starve_cnt=0, all grants/rvalid/mem_cs/mem_we=0, mem_addr/wdata/be=0, rdata outputs 0.
REQ-036 Reset mid-transaction discards pending response; first cycle after release may grant.

Structure
REQ-037 ADDR_WIDTH/DATA_WIDTH/INSTR_WIDTH from core_defines.vh; rsp_own encoding constants in shared package/header.
REQ-038 Single module; optional sub-module imem_arb_prio (grant + starvation counter).

Verification
REQ-039 if_req only, addr 0x100,0x104, mem_ready=1 -> if_gnt each cycle, if_rvalid one cycle later with mem_rdata.
REQ-040 if_req+dm_req continuous, STARVE_LIMIT=3 -> grant pattern D,D,D,I repeating.
REQ-041 Fetch granted at 0x200, if_flush next cycle -> no if_rvalid for 0x200; following fetch 0x300 returned normally.
REQ-042 mem_ready=0 for 3 cycles with DM read pending -> no grants, mem_* stable, dm_rvalid once after mem_ready rises.
REQ-043 DM write 0xDEADBEEF to 0x40 then DM read 0x40 -> no rvalid for write, dm_rdata=0xDEADBEEF; reset asserted mid-read -> all outputs 0, no rvalid.
